// File: rtl/fp16_pkg.sv
// Shared binary16 constants, the operand classification enum and the field packer
// used by the half-precision encoder.
package fp16_pkg;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;
  localparam int FP16_FRAC_W  = 10;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_INF_EXP = 5'h1F;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} fp_kind_e;

  function automatic logic [15:0] pack_fp16(input logic s, input logic [4:0] e,
                                            input logic [FP16_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction
endpackage

// File: rtl/fp16_encode_if.sv
// Operand-in / result-out handshake bundle for the fp16 encoder.
interface fp16_encode_if #(parameter int MANT_W = 24, parameter int EXP_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic              sign_half;
  logic [EXP_W-1:0]  exp_half;
  logic [MANT_W-1:0] mant_half;
  logic              is_nan_half;
  logic              is_inf_half;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       result_half;
  logic              ovf_half;
  logic              unf_half;
  logic              inexact_half;

  modport master (output in_valid, sign_half, exp_half, mant_half, is_nan_half, is_inf_half,
                  output out_ready,
                  input  in_ready, out_valid, result_half, ovf_half, unf_half, inexact_half);
  modport slave  (input  in_valid, sign_half, exp_half, mant_half, is_nan_half, is_inf_half,
                  input  out_ready,
                  output in_ready, out_valid, result_half, ovf_half, unf_half, inexact_half);
endinterface

// File: rtl/fp16_lzc.sv
// Combinational leading-zero count; an all-zero vector reports W.
module fp16_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    // Ascending scan: the highest set bit is the last one to write cnt.
    for (int i = 0; i < W; i++)
      if (vec[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp16_encode.sv
// Two-stage binary16 encoder: stage 1 normalizes/denormalizes, stage 2 rounds
// to nearest-even and packs. Valid/ready with per-stage advance.
module fp16_encode
  import fp16_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  fp16_encode_if.slave  bus
);
  localparam int IB  = MANT_W - 3;          // integer-bit position
  localparam int HR  = MANT_W - 1 - IB;     // carry headroom bits above IB
  localparam int LW  = $clog2(MANT_W + 1);
  localparam int XW  = EXP_W + 1;
  localparam int KW  = FP16_FRAC_W + 1;

  function automatic logic [MANT_W-1:0] shr_sticky(input logic [MANT_W-1:0] m,
                                                   input logic [LW:0] amt);
    logic [MANT_W-1:0] lost;
    lost = m & ~({MANT_W{1'b1}} << amt);
    return (m >> amt) | {{(MANT_W-1){1'b0}}, |lost};
  endfunction

  logic [2:1] vld_pipe;
  logic       s2_rdy, in_rdy;

  assign s2_rdy = !vld_pipe[2] || bus.out_ready;
  assign in_rdy = !vld_pipe[1] || s2_rdy;

  // ---- stage 1: classify and normalize ----
  logic [LW-1:0]        lz;
  fp_kind_e             kind_n;
  logic signed [XW-1:0] e_n;
  logic [MANT_W-1:0]    m_n;
  logic [XW-1:0]        dn;
  logic [LW:0]          sh;
  logic                 tiny_n;

  fp16_lzc #(.W(MANT_W)) u_lzc (.vec(bus.mant_half), .cnt(lz));

  always_comb begin
    kind_n = K_NORM;
    if (bus.is_nan_half)           kind_n = K_NAN;
    else if (bus.is_inf_half)      kind_n = K_INF;
    else if (bus.mant_half == '0)  kind_n = K_ZERO;
    e_n = {bus.exp_half[EXP_W-1], bus.exp_half} + XW'(HR) - XW'(lz);
    sh  = '0;
    if (lz < LW'(HR)) m_n = shr_sticky(bus.mant_half, {1'b0, LW'(HR) - lz});
    else              m_n = bus.mant_half << (lz - LW'(HR));
    tiny_n = 1'b0;
    dn     = '0;
    if (e_n <= 0) begin
      // Denormalize so the value sits at exponent 1; far-tiny inputs become pure sticky.
      dn     = XW'(1) - e_n;
      sh     = (dn > XW'(MANT_W)) ? (LW+1)'(MANT_W) : dn[LW:0];
      m_n    = shr_sticky(m_n, sh);
      e_n    = '0;
      tiny_n = 1'b1;
    end
  end

  fp_kind_e             s1_kind;
  logic                 s1_sign, s1_tiny;
  logic signed [XW-1:0] s1_e;
  logic [MANT_W-1:0]    s1_m;

  // ---- stage 2: round to nearest-even and pack ----
  logic [KW-1:0]        kept, kept2;
  logic [KW:0]          sum;
  logic                 g, st, inc;
  logic signed [XW-1:0] e2;
  logic [15:0]          res_n;
  logic                 ovf_n, unf_n, inx_n;

  always_comb begin
    kept  = s1_m[IB -: KW];
    g     = s1_m[IB-KW];
    st    = |s1_m[IB-KW-1:0];
    inc   = g & (st | kept[0]);
    sum   = {1'b0, kept} + (KW+1)'(inc);
    e2    = s1_e;
    kept2 = sum[KW-1:0];
    if (sum[KW]) begin
      kept2 = sum[KW:1];
      e2    = s1_e + XW'(1);
    end
    if (e2 == 0 && kept2[KW-1]) e2 = XW'(1);
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inx_n = 1'b0;
    case (s1_kind)
      K_NAN:  res_n = FP16_QNAN;
      K_INF:  res_n = pack_fp16(s1_sign, FP16_INF_EXP, '0);
      K_ZERO: res_n = pack_fp16(s1_sign, 5'h0, '0);
      default: begin
        inx_n = g | st;
        if (e2 >= FP16_EXP_MAX) begin
          res_n = pack_fp16(s1_sign, FP16_INF_EXP, '0);
          ovf_n = 1'b1;
          inx_n = 1'b1;
        end else begin
          res_n = pack_fp16(s1_sign, e2[4:0], kept2[FP16_FRAC_W-1:0]);
        end
        unf_n = s1_tiny & inx_n;
      end
    endcase
  end

  logic [15:0] res_q;
  logic        ovf_q, unf_q, inx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      if (s2_rdy) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          res_q <= res_n;
          ovf_q <= ovf_n;
          unf_q <= unf_n;
          inx_q <= inx_n;
        end
      end
      if (in_rdy) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          s1_kind <= kind_n;
          s1_sign <= bus.sign_half;
          s1_e    <= e_n;
          s1_m    <= m_n;
          s1_tiny <= tiny_n;
        end
      end
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = vld_pipe[2];
  assign bus.result_half  = res_q;
  assign bus.ovf_half     = ovf_q;
  assign bus.unf_half     = unf_q;
  assign bus.inexact_half = inx_q;
endmodule

// File: tb/tb_fp16_encode.sv
// Directed-vector bench for fp16_encode: special values, rounding, overflow,
// subnormals, backpressure ordering and reset flush.
module tb_fp16_encode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp16_encode_if #(.MANT_W(24), .EXP_W(8)) bus();
  fp16_encode #(.MANT_W(24), .EXP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic nan, input logic inf);
    bus.sign_half   = s;
    bus.exp_half    = e;
    bus.mant_half   = m;
    bus.is_nan_half = nan;
    bus.is_inf_half = inf;
  endtask

  // One isolated operand with out_ready=1; result must appear exactly two cycles later.
  task automatic one(input string tag, input logic s, input logic [7:0] e, input logic [23:0] m,
                     input logic nan, input logic inf, input logic [15:0] xr, input logic [2:0] xf);
    drive(s, e, m, nan, inf);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk(tag, 32'(bus.result_half), 32'(xr));
    chk({tag, "_flg"}, 32'({bus.ovf_half, bus.unf_half, bus.inexact_half}), 32'(xf));
    @(posedge clk); #1;
  endtask

  logic [7:0]  ve [4];
  logic [23:0] vm [4];
  logic [15:0] vr [4];

  initial begin
    int sent, got, seen;
    logic fire_in, fire_out;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 8'h0, 24'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.result_half), 32'h0);
    chk("rst_flg", 32'({bus.ovf_half, bus.unf_half, bus.inexact_half}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    one("one",      1'b0, 8'h0F, 24'h200000, 1'b0, 1'b0, 16'h3C00, 3'b000);
    one("rne_tie",  1'b0, 8'h0F, 24'h3FFC00, 1'b0, 1'b0, 16'h4000, 3'b001);
    one("ovf",      1'b1, 8'h1F, 24'h200000, 1'b0, 1'b0, 16'hFC00, 3'b101);
    one("inf",      1'b1, 8'h1F, 24'h200000, 1'b0, 1'b1, 16'hFC00, 3'b000);
    one("sub_min",  1'b0, 8'hF7, 24'h200000, 1'b0, 1'b0, 16'h0001, 3'b000);
    one("sub_unf",  1'b0, 8'hF6, 24'h200000, 1'b0, 1'b0, 16'h0000, 3'b011);
    one("zero",     1'b1, 8'h0F, 24'h000000, 1'b0, 1'b0, 16'h8000, 3'b000);
    one("nan",      1'b1, 8'h55, 24'h123456, 1'b1, 1'b1, 16'h7E00, 3'b000);
    one("hdroom",   1'b0, 8'h0E, 24'h400000, 1'b0, 1'b0, 16'h3C00, 3'b000);
    one("leftnorm", 1'b0, 8'h10, 24'h100000, 1'b0, 1'b0, 16'h3C00, 3'b000);

    // Backpressure: four operands, downstream stalled for the first four cycles.
    ve[0] = 8'h0F; vm[0] = 24'h200000; vr[0] = 16'h3C00;
    ve[1] = 8'h10; vm[1] = 24'h200000; vr[1] = 16'h4000;
    ve[2] = 8'h0E; vm[2] = 24'h200000; vr[2] = 16'h3800;
    ve[3] = 8'h0F; vm[3] = 24'h300000; vr[3] = 16'h3E00;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (sent < 4);
      if (sent < 4) drive(1'b0, ve[sent], vm[sent], 1'b0, 1'b0);
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        chk($sformatf("hold_vld%0d", cyc), 32'(bus.out_valid), 32'd1);
        chk($sformatf("hold_res%0d", cyc), 32'(bus.result_half), 32'h3C00);
      end
      if (cyc == 3) begin
        chk("bp_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_sent", 32'(sent), 32'd2);
      end
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (fire_out) begin
        if (got < 4) chk($sformatf("order%0d", got), 32'(bus.result_half), 32'(vr[got]));
        got++;
      end
      @(posedge clk); #1;
      if (fire_in) sent++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd4);
    @(negedge clk);
    chk("bp_nodup", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with two operands in flight must drop both.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, ve[k], vm[k], 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_vld", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_none", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
